// File: rtl/radial_ring_gen_if.sv
// Pixel-stream bundle for the radial ring generator.
//   master: pattern source / timing side (drives control + pixel, receives rgb)
//   slave : radial_ring_gen (consumes control + pixel, drives rgb)
//   pattern_enable, next_frame, step_size[11:0] (8.4), mode_metric[1:0],
//   mode_motion[1:0], x/y[COORD_W-1:0], active, rgb[5:0]
interface radial_ring_gen_if #(
  parameter int COORD_W = 10
);
  logic               pattern_enable;
  logic               next_frame;
  logic [11:0]        step_size;
  logic [1:0]         mode_metric;
  logic [1:0]         mode_motion;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               active;
  logic [5:0]         rgb;

  modport master (
    output pattern_enable, next_frame, step_size, mode_metric, mode_motion,
           x, y, active,
    input  rgb
  );

  modport slave (
    input  pattern_enable, next_frame, step_size, mode_metric, mode_motion,
           x, y, active,
    output rgb
  );
endinterface

// File: rtl/radial_ring_gen.sv
// Radial ring pattern generator: RING_COUNT concentric rings around
// (CENTER_X, CENTER_Y) with selectable distance metric and ring motion.
//   clk  : pixel clock
//   rst  : asynchronous active-high reset
//   bus  : radial_ring_gen_if.slave (control, pixel in, rgb out)
// Pixel path is 3 registered stages (abs deltas, distance, colour); the
// animation phase advances once per qualifying next_frame pulse.
module radial_ring_gen #(
  parameter int COORD_W      = 10,
  parameter int PHASE_W      = 10,
  parameter int RING_COUNT   = 5,
  parameter int RING_SPACING = 24,
  parameter int BASE_OFFSET  = 30,
  parameter int CENTER_X     = 320,
  parameter int CENTER_Y     = 240,
  parameter int PHASE_MAX    = 500
) (
  input logic         clk,
  input logic         rst,
  radial_ring_gen_if.slave bus
);
  localparam int AW = COORD_W + 1;
  localparam int DW = COORD_W + 2;
  localparam int SW = PHASE_W + 2;  // room for unwrapped sum / signed difference
  localparam logic [AW-1:0] CX   = AW'(CENTER_X);
  localparam logic [AW-1:0] CY   = AW'(CENTER_Y);
  localparam logic [SW-1:0] PMAX = SW'(PHASE_MAX);
  // PAL[k-1] is ring k's colour
  localparam logic [7:0][5:0] PAL = {6'b100001, 6'b000010, 6'b000100, 6'b001000,
                                     6'b001100, 6'b101000, 6'b101100, 6'b101101};
  localparam logic [5:0] EDGE = 6'b000001;

  typedef enum logic {DIR_OUT, DIR_IN} dir_e;

  // ---------------- animation phase ----------------
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [3:0]         frac_q, frac_d;
  dir_e               dir_q, dir_d;

  logic [7:0]    st_int;
  logic [3:0]    st_fr;
  logic [4:0]    add_f, sub_f;
  logic [SW-1:0] sum_u, dif_u;
  logic          dif_le0;

  assign st_int  = bus.step_size[11:4];
  assign st_fr   = bus.step_size[3:0];
  assign add_f   = {1'b0, frac_q} + {1'b0, st_fr};
  assign sub_f   = {1'b0, frac_q} - {1'b0, st_fr};  // bit 4 = borrow
  assign sum_u   = SW'(phase_q) + SW'(st_int) + SW'(add_f[4]);
  assign dif_u   = SW'(phase_q) - SW'(st_int) - SW'(sub_f[4]);
  // MSB set means the difference went negative
  assign dif_le0 = dif_u[SW-1] || (dif_u == '0);

  always_comb begin
    phase_d = phase_q;
    frac_d  = frac_q;
    dir_d   = dir_q;
    if (bus.next_frame && bus.pattern_enable) begin
      dir_d = DIR_OUT;
      case (bus.mode_motion)
        2'd0: begin
          phase_d = sum_u[PHASE_W-1:0];
          frac_d  = add_f[3:0];
        end
        2'd1: begin
          phase_d = dif_u[PHASE_W-1:0];
          frac_d  = sub_f[3:0];
        end
        2'd2: begin
          dir_d = dir_q;
          // zero step must never trigger a turn, even when parked at a limit
          if (bus.step_size != '0) begin
            if (dir_q == DIR_OUT) begin
              if (sum_u >= PMAX) begin
                phase_d = PHASE_W'(PHASE_MAX);
                frac_d  = '0;
                dir_d   = DIR_IN;
              end else begin
                phase_d = sum_u[PHASE_W-1:0];
                frac_d  = add_f[3:0];
              end
            end else begin
              if (dif_le0) begin
                phase_d = '0;
                frac_d  = '0;
                dir_d   = DIR_OUT;
              end else begin
                phase_d = dif_u[PHASE_W-1:0];
                frac_d  = sub_f[3:0];
              end
            end
          end
        end
        default: ;  // freeze
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      frac_q  <= '0;
      dir_q   <= DIR_OUT;
    end else begin
      phase_q <= phase_d;
      frac_q  <= frac_d;
      dir_q   <= dir_d;
    end
  end

  // ---------------- pixel pipeline ----------------
  logic [AW-1:0] ax_d, ay_d, ax_q, ay_q;
  logic [1:0]    met_d, met_q;
  logic [1:0]    act_d, act_q;  // [0] at S1, [1] at S2
  logic [AW-1:0] mx, mn;
  logic [DW-1:0] dist_d, dist_q;
  logic [DW-1:0] base, r1, rad;
  logic [5:0]    rgb_d, rgb_q;

  // S1: absolute deltas from the centre
  always_comb begin
    ax_d  = ({1'b0, bus.x} >= CX) ? {1'b0, bus.x} - CX : CX - {1'b0, bus.x};
    ay_d  = ({1'b0, bus.y} >= CY) ? {1'b0, bus.y} - CY : CY - {1'b0, bus.y};
    met_d = bus.mode_metric;
    act_d = {act_q[0], bus.active};
  end

  // S2: distance metric
  always_comb begin
    mx = (ax_q > ay_q) ? ax_q : ay_q;
    mn = (ax_q > ay_q) ? ay_q : ax_q;
    case (met_q)
      2'd1:    dist_d = DW'(mx);
      2'd2:    dist_d = DW'(mx) + DW'(mn >> 1);
      default: dist_d = DW'(ax_q) + DW'(ay_q);
    endcase
  end

  // S3: ring lookup against the live phase
  always_comb begin
    base  = DW'(BASE_OFFSET) + DW'(phase_q >> 1);
    r1    = (base > DW'(RING_SPACING)) ? base - DW'(RING_SPACING) : '0;
    rad   = '0;
    rgb_d = EDGE;
    // walk outer to inner so the innermost matching ring wins
    for (int k = RING_COUNT; k >= 1; k--) begin
      rad = (k == 1) ? r1 : base + DW'((k - 2) * RING_SPACING);
      if (dist_q <= rad) rgb_d = PAL[3'(k - 1)];
    end
    if (!act_q[1]) rgb_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_q   <= '0;
      ay_q   <= '0;
      met_q  <= '0;
      act_q  <= '0;
      dist_q <= '0;
      rgb_q  <= '0;
    end else begin
      ax_q   <= ax_d;
      ay_q   <= ay_d;
      met_q  <= met_d;
      act_q  <= act_d;
      dist_q <= dist_d;
      rgb_q  <= rgb_d;
    end
  end

  assign bus.rgb = rgb_q;
endmodule
